// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit
//   Load/store responder that owns a word-wide synchronous data RAM.
//   Serves word, halfword and byte accesses; sub-word stores are
//   read-modify-write, and loads are extended to 32 bits.
//   Optional feature macro: UNSIGNED_LOAD_EN adds the MemUnsigned input so that
//   byte and halfword loads can be zero-extended (lbu/lhu).
module data_mem_access_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
`ifdef UNSIGNED_LOAD_EN
  input  logic        MemUnsigned,
`endif
  output logic [31:0] ReadData,
  output logic        Busy,
  output logic        Done,
  output logic        Err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] RESP   = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] ERRRSP = 3'd4;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [1:0]            size_q;
  logic [31:0]           wdata_q;
  logic                  store_q;
  logic [31:0]           rdata_q;
  logic [31:0]           rd_out_q;
  logic                  done_q, err_q;
  logic                  load_uns;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            off;
  logic [31:0]           fetch_word;
  logic [31:0]           store_word;
  logic                  req, reject;

  // Address bits above the RAM window alias onto it, so they are dropped.
  logic unused_addr;
  assign unused_addr = ^Address[31:ADDR_WIDTH+2];

  assign idx        = addr_q[ADDR_WIDTH+1:2];
  assign off        = addr_q[1:0];
  assign fetch_word = mem[idx];

  assign req    = MemRead | MemWrite;
  assign reject = (MemRead & MemWrite) ||
                  (MemSize == SZ_RSVD) ||
                  (MemSize == SZ_HALF && Address[0]) ||
                  (MemSize == SZ_WORD && Address[1:0] != 2'b00);

  // Pick the addressed lane out of a word and extend it to 32 bits.
  function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] o, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{o, 3'b000} +: 8];
    h = w[{o[1], 4'b0000} +: 16];
    case (sz)
      SZ_HALF: extend_load = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      SZ_BYTE: extend_load = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      default: extend_load = w;
    endcase
  endfunction

  // Replace the addressed lane of the old word with new store data.
  function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] o);
    logic [31:0] m;
    m = old;
    case (sz)
      SZ_HALF: m[{o[1], 4'b0000} +: 16] = wd[15:0];
      SZ_BYTE: m[{o, 3'b000} +: 8]      = wd[7:0];
      default: m = wd;
    endcase
    merge_store = m;
  endfunction

  assign store_word = merge_store(rdata_q, wdata_q, size_q, off);

  // Next-state: accept in IDLE, then walk the fixed sequence for the access kind.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (reject)                 state_d = ERRRSP;
          else if (MemRead)           state_d = FETCH;
          else if (MemSize == SZ_WORD) state_d = WRITE;
          else                        state_d = FETCH;
        end
      end
      FETCH:   state_d = store_q ? WRITE : RESP;
      RESP,
      WRITE,
      ERRRSP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state, request latch and registered response flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      size_q   <= SZ_WORD;
      wdata_q  <= '0;
      store_q  <= 1'b0;
      rd_out_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) begin
        addr_q  <= Address[ADDR_WIDTH+1:0];
        size_q  <= MemSize;
        wdata_q <= WriteData;
        store_q <= MemWrite;
      end
      // ReadData changes only on the edge that enters RESP.
      if (state_q == FETCH && !store_q)
        rd_out_q <= extend_load(fetch_word, size_q, off, load_uns);
      done_q <= (state_d == RESP) || (state_d == WRITE) || (state_d == ERRRSP);
      err_q  <= (state_d == ERRRSP);
    end
  end

`ifdef UNSIGNED_LOAD_EN
  logic uns_q;
  // Zero-extend selection travels with the request.
  always_ff @(posedge Clk) begin
    if (Reset)                        uns_q <= 1'b0;
    else if (state_q == IDLE && req)  uns_q <= MemUnsigned;
  end
  assign load_uns = uns_q;
`else
  assign load_uns = 1'b0;
`endif

  // RAM port: registered read in FETCH, write in WRITE unless reset aborts it.
  always_ff @(posedge Clk) begin
    if (state_q == FETCH) rdata_q <= fetch_word;
    if (!Reset && state_q == WRITE) mem[idx] <= store_word;
  end

  assign ReadData = rd_out_q;
  assign Busy     = (state_q != IDLE);
  assign Done     = done_q;
  assign Err      = err_q;

endmodule
